// File: rtl/arya_dispatch_pkg.sv
// Shared types and defaults for the thread dispatcher and its per-thread slots.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arya_dispatch_pkg;

   // Per-thread slot lifecycle
   typedef enum logic [1:0] {
      SLOT_IDLE   = 2'd0,
      SLOT_LAUNCH = 2'd1,
      SLOT_RUN    = 2'd2,
      SLOT_KICK   = 2'd3
   } slot_state_t;

   localparam int SLOT_STATE_W           = 2;
   localparam int WD_W                   = 16;    // watchdog counter width, covers 2..65535
   localparam int DEFAULT_TIMEOUT_CYCLES = 1100;

endpackage

// File: rtl/dispatch_slot.sv
// Per-thread slot: IDLE/LAUNCH/RUN/KICK FSM with a saturating RUN watchdog.
// Latency: start/kick pulses are registered, one cycle after the state decision.
// Backpressure: none; launch is only asserted by the top while the slot is idle.
//
// Ports: launch (from top arbiter), done (thread completion), debug_on (allow kicks),
//        idle (slot free), done_fire (completion accepted this cycle, combinational),
//        start_pulse / kick_pulse (registered one-cycle pulses), timeout_err (sticky).
module dispatch_slot
   import arya_dispatch_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic reset_n,
   input  logic launch,
   input  logic done,
   input  logic debug_on,
   output logic idle,
   output logic done_fire,
   output logic start_pulse,
   output logic kick_pulse,
   output logic timeout_err
);

   localparam logic [WD_W-1:0] TIMEOUT = WD_W'(TIMEOUT_CYCLES);

   slot_state_t     state_q, state_n;
   logic [WD_W-1:0] wd_q, wd_n, wd_inc;
   logic            err_n;

   // Saturating increment: once at the limit the expiry condition stays true,
   // so enabling debug_on later still produces a kick.
   assign wd_inc = (wd_q == TIMEOUT) ? TIMEOUT : wd_q + WD_W'(1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= SLOT_IDLE;
         wd_q        <= '0;
         timeout_err <= 1'b0;
         start_pulse <= 1'b0;
         kick_pulse  <= 1'b0;
      end else begin
         state_q     <= state_n;
         wd_q        <= wd_n;
         timeout_err <= err_n;
         start_pulse <= (state_n == SLOT_LAUNCH);
         kick_pulse  <= (state_n == SLOT_KICK);
      end
   end

   always_comb begin
      state_n   = state_q;
      wd_n      = wd_q;
      err_n     = timeout_err;
      done_fire = 1'b0;
      unique case (state_q)
         SLOT_IDLE: begin
            if (launch) state_n = SLOT_LAUNCH;
         end
         SLOT_LAUNCH: begin
            // completions from the previous occupant are ignored here
            state_n = SLOT_RUN;
            wd_n    = '0;
         end
         SLOT_RUN: begin
            if (done) begin
               // completion wins over a same-cycle expiry
               state_n   = SLOT_IDLE;
               done_fire = 1'b1;
            end else begin
               wd_n = wd_inc;
               if (wd_inc == TIMEOUT) begin
                  err_n = 1'b1;
                  if (debug_on) state_n = SLOT_KICK;
               end
            end
         end
         SLOT_KICK: begin
            if (done) begin
               state_n   = SLOT_IDLE;
               done_fire = 1'b1;
            end else begin
               state_n = SLOT_RUN;
               wd_n    = '0;
            end
         end
         default: state_n = SLOT_IDLE;
      endcase
   end

   assign idle = (state_q == SLOT_IDLE);

endmodule

// File: rtl/thread_dispatcher.sv
// Round-robin job dispatcher onto per-thread slots with watchdog and completion counter.
// Latency: job accepted at edge t -> start_thread/dispatch_valid high in the following cycle.
// Backpressure: job_ready low (combinationally) while no slot is idle.
//
// Ports: job_valid/job_ready handshake, debug_on enables kicks, thread_busy (unused,
//        stale threads are caught by the watchdog), thread_done completions,
//        start_thread/debug_commands per-thread pulses, dispatch_valid/dispatch_id,
//        timeout_err sticky flags, done_count saturating total, all_idle.
module thread_dispatcher
   import arya_dispatch_pkg::*;
#(
   parameter int NUM_THREADS_PER_CORE = 4,
   parameter int TIMEOUT_CYCLES       = DEFAULT_TIMEOUT_CYCLES,
   parameter int DONE_COUNT_WIDTH     = 16,
   localparam int N   = NUM_THREADS_PER_CORE,
   localparam int IDW = (NUM_THREADS_PER_CORE > 1) ? $clog2(NUM_THREADS_PER_CORE) : 1
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        job_valid,
   output logic                        job_ready,
   input  logic                        debug_on,
   input  logic [N-1:0]                thread_busy,
   input  logic [N-1:0]                thread_done,
   output logic [N-1:0]                start_thread,
   output logic [N-1:0]                debug_commands,
   output logic                        dispatch_valid,
   output logic [IDW-1:0]              dispatch_id,
   output logic [N-1:0]                timeout_err,
   output logic [DONE_COUNT_WIDTH-1:0] done_count,
   output logic                        all_idle
);

   logic [N-1:0]              slot_idle;
   logic [N-1:0]              done_fire;
   logic [N-1:0]              launch;
   logic [IDW-1:0]            rr_ptr;
   logic [IDW-1:0]            cand;
   logic [IDW-1:0]            pick_idx;
   logic                      pick_found;
   logic                      accept;
   logic [DONE_COUNT_WIDTH:0] done_inc;
   logic [DONE_COUNT_WIDTH:0] done_sum;

   // Stale/hung threads are caught by the RUN watchdog, so busy carries no logic.
   logic unused_thread_busy;
   assign unused_thread_busy = ^thread_busy;

   for (genvar i = 0; i < N; i++) begin : g_slot
      dispatch_slot #(
         .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
      ) u_slot (
         .clk         (clk),
         .reset_n     (reset_n),
         .launch      (launch[i]),
         .done        (thread_done[i]),
         .debug_on    (debug_on),
         .idle        (slot_idle[i]),
         .done_fire   (done_fire[i]),
         .start_pulse (start_thread[i]),
         .kick_pulse  (debug_commands[i]),
         .timeout_err (timeout_err[i])
      );
   end

   assign job_ready = |slot_idle;
   assign all_idle  = &slot_idle;

   // First idle slot at or after rr_ptr, wrapping. Idle comes from slot state
   // registers, so a slot freed this cycle is only offered next cycle.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int k = 0; k < N; k++) begin
         cand = IDW'((int'(rr_ptr) + k) % N);
         if (!pick_found && slot_idle[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   assign accept = job_valid && pick_found;

   always_comb begin
      launch = '0;
      if (accept) launch[pick_idx] = 1'b1;
   end

   always_comb begin
      done_inc = '0;
      for (int i = 0; i < N; i++) begin
         done_inc = done_inc + {{DONE_COUNT_WIDTH{1'b0}}, done_fire[i]};
      end
      done_sum = {1'b0, done_count} + done_inc;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr         <= '0;
         dispatch_valid <= 1'b0;
         dispatch_id    <= '0;
         done_count     <= '0;
      end else begin
         dispatch_valid <= accept;
         dispatch_id    <= accept ? pick_idx : '0;
         if (accept) rr_ptr <= IDW'((int'(pick_idx) + 1) % N);
         done_count     <= done_sum[DONE_COUNT_WIDTH] ? '1 : done_sum[DONE_COUNT_WIDTH-1:0];
      end
   end

endmodule

// File: tb/tb_thread_dispatcher.sv
module tb_thread_dispatcher;

   logic       clk;
   logic       reset_n;
   logic       job_valid;
   logic       job_ready;
   logic       debug_on;
   logic [3:0] thread_busy;
   logic [3:0] thread_done;
   logic [3:0] start_thread;
   logic [3:0] debug_commands;
   logic       dispatch_valid;
   logic [1:0] dispatch_id;
   logic [3:0] timeout_err;
   logic [3:0] done_count;
   logic       all_idle;

   int checks = 0;
   int passes = 0;

   thread_dispatcher #(
      .NUM_THREADS_PER_CORE(4),
      .TIMEOUT_CYCLES      (8),
      .DONE_COUNT_WIDTH    (4)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .job_valid      (job_valid),
      .job_ready      (job_ready),
      .debug_on       (debug_on),
      .thread_busy    (thread_busy),
      .thread_done    (thread_done),
      .start_thread   (start_thread),
      .debug_commands (debug_commands),
      .dispatch_valid (dispatch_valid),
      .dispatch_id    (dispatch_id),
      .timeout_err    (timeout_err),
      .done_count     (done_count),
      .all_idle       (all_idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
      $fatal(1);
   end

   task automatic test_reset();
      reset_n = 1'b0; job_valid = 1'b0; debug_on = 1'b0;
      thread_busy = '0; thread_done = '0;
      repeat (3) @(negedge clk);
      checks++; if (start_thread !== 4'b0000) $display("FAIL rst_start: got %b want 0000", start_thread); else passes++;
      checks++; if (debug_commands !== 4'b0000) $display("FAIL rst_dbg: got %b want 0000", debug_commands); else passes++;
      checks++; if (dispatch_valid !== 1'b0) $display("FAIL rst_dvalid: got %b want 0", dispatch_valid); else passes++;
      checks++; if (dispatch_id !== 2'd0) $display("FAIL rst_did: got %0d want 0", dispatch_id); else passes++;
      checks++; if (timeout_err !== 4'b0000) $display("FAIL rst_terr: got %b want 0000", timeout_err); else passes++;
      checks++; if (done_count !== 4'd0) $display("FAIL rst_cnt: got %0d want 0", done_count); else passes++;
      checks++; if (all_idle !== 1'b1) $display("FAIL rst_idle: got %b want 1", all_idle); else passes++;
      reset_n = 1'b1;
      @(negedge clk);
      checks++; if (job_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", job_ready); else passes++;
   endtask

   // Four back-to-back jobs land on slots 0..3 on consecutive cycles.
   task automatic test_fill();
      job_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (start_thread !== 4'(1 << i)) $display("FAIL fill_start%0d: got %b want %b", i, start_thread, 4'(1 << i)); else passes++;
         checks++; if (dispatch_valid !== 1'b1) $display("FAIL fill_dvalid%0d: got %b want 1", i, dispatch_valid); else passes++;
         checks++; if (dispatch_id !== 2'(i)) $display("FAIL fill_did%0d: got %0d want %0d", i, dispatch_id, i); else passes++;
      end
      checks++; if (job_ready !== 1'b0) $display("FAIL fill_ready: got %b want 0", job_ready); else passes++;
      checks++; if (all_idle !== 1'b0) $display("FAIL fill_idle: got %b want 0", all_idle); else passes++;
      job_valid = 1'b0;
   endtask

   // Slot 2 completes, is reused by the next job; done during LAUNCH is ignored.
   task automatic test_done_single();
      thread_done = 4'b0100;
      @(negedge clk);
      thread_done = 4'b0000;
      checks++; if (done_count !== 4'd1) $display("FAIL single_cnt: got %0d want 1", done_count); else passes++;
      checks++; if (job_ready !== 1'b1) $display("FAIL single_ready: got %b want 1", job_ready); else passes++;
      job_valid = 1'b1;
      @(negedge clk);
      job_valid = 1'b0;
      checks++; if (start_thread !== 4'b0100) $display("FAIL single_restart: got %b want 0100", start_thread); else passes++;
      checks++; if (dispatch_id !== 2'd2) $display("FAIL single_did: got %0d want 2", dispatch_id); else passes++;
      checks++; if (job_ready !== 1'b0) $display("FAIL single_ready2: got %b want 0", job_ready); else passes++;
      thread_done = 4'b0100;
      @(negedge clk);
      thread_done = 4'b0000;
      checks++; if (done_count !== 4'd1) $display("FAIL launch_done_ignored: got %0d want 1", done_count); else passes++;
   endtask

   task automatic test_done_all();
      thread_done = 4'b1111;
      @(negedge clk);
      thread_done = 4'b0000;
      checks++; if (done_count !== 4'd5) $display("FAIL all_cnt: got %0d want 5", done_count); else passes++;
      checks++; if (all_idle !== 1'b1) $display("FAIL all_idle: got %b want 1", all_idle); else passes++;
      checks++; if (timeout_err !== 4'b0000) $display("FAIL all_terr: got %b want 0000", timeout_err); else passes++;
   endtask

   // debug_on=0: slot 3 times out, flag set, no kick, slot stays RUN.
   task automatic test_timeout_nodebug();
      int bad_dbg;
      debug_on = 1'b0;
      job_valid = 1'b1;
      @(negedge clk);
      job_valid = 1'b0;
      checks++; if (start_thread !== 4'b1000) $display("FAIL nd_start: got %b want 1000", start_thread); else passes++;
      repeat (8) @(negedge clk);
      checks++; if (timeout_err !== 4'b0000) $display("FAIL nd_terr_early: got %b want 0000", timeout_err); else passes++;
      @(negedge clk);
      checks++; if (timeout_err !== 4'b1000) $display("FAIL nd_terr: got %b want 1000", timeout_err); else passes++;
      bad_dbg = 0;
      for (int k = 0; k < 12; k++) begin
         if (debug_commands !== 4'b0000) bad_dbg++;
         @(negedge clk);
      end
      checks++; if (bad_dbg != 0) $display("FAIL nd_no_kick: got %0d kick cycles want 0", bad_dbg); else passes++;
      checks++; if (all_idle !== 1'b0) $display("FAIL nd_still_run: got all_idle %b want 0", all_idle); else passes++;
      thread_done = 4'b1000;
      @(negedge clk);
      thread_done = 4'b0000;
      checks++; if (done_count !== 4'd6) $display("FAIL nd_cnt: got %0d want 6", done_count); else passes++;
      checks++; if (timeout_err !== 4'b1000) $display("FAIL nd_sticky: got %b want 1000", timeout_err); else passes++;
   endtask

   // debug_on=1: kicks at RUN+8, RUN+17, RUN+26; done during KICK is counted.
   task automatic test_debug_kick();
      logic [3:0] exp_dbg;
      logic [3:0] exp_err;
      debug_on = 1'b1;
      job_valid = 1'b1;
      @(negedge clk);
      job_valid = 1'b0;
      checks++; if (start_thread !== 4'b0001) $display("FAIL dk_start: got %b want 0001", start_thread); else passes++;
      for (int k = 0; k < 27; k++) begin
         @(negedge clk);
         exp_dbg = (k == 8 || k == 17 || k == 26) ? 4'b0001 : 4'b0000;
         exp_err = (k >= 8) ? 4'b1001 : 4'b1000;
         checks++; if (debug_commands !== exp_dbg) $display("FAIL dk_dbg_k%0d: got %b want %b", k, debug_commands, exp_dbg); else passes++;
         checks++; if (timeout_err !== exp_err) $display("FAIL dk_terr_k%0d: got %b want %b", k, timeout_err, exp_err); else passes++;
      end
      thread_done = 4'b0001;
      @(negedge clk);
      thread_done = 4'b0000;
      debug_on = 1'b0;
      checks++; if (done_count !== 4'd7) $display("FAIL dk_cnt: got %0d want 7", done_count); else passes++;
      checks++; if (all_idle !== 1'b1) $display("FAIL dk_idle: got %b want 1", all_idle); else passes++;
   endtask

   task automatic launch_all();
      job_valid = 1'b1;
      repeat (4) @(negedge clk);
      job_valid = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_saturation();
      logic [3:0] exp_cnt [3];
      exp_cnt[0] = 4'd11; exp_cnt[1] = 4'd15; exp_cnt[2] = 4'd15;
      for (int r = 0; r < 3; r++) begin
         launch_all();
         thread_done = 4'b1111;
         @(negedge clk);
         thread_done = 4'b0000;
         checks++; if (done_count !== exp_cnt[r]) $display("FAIL sat_cnt%0d: got %0d want %0d", r, done_count, exp_cnt[r]); else passes++;
      end
      job_valid = 1'b1;
      @(negedge clk);
      job_valid = 1'b0;
      @(negedge clk);
      thread_done = 4'b1111;
      @(negedge clk);
      thread_done = 4'b0000;
      checks++; if (done_count !== 4'd15) $display("FAIL sat_hold: got %0d want 15", done_count); else passes++;
      checks++; if (all_idle !== 1'b1) $display("FAIL sat_idle: got %b want 1", all_idle); else passes++;
      checks++; if (timeout_err !== 4'b1001) $display("FAIL sat_terr: got %b want 1001", timeout_err); else passes++;
   endtask

   task automatic test_reset_midlaunch();
      int bad;
      job_valid = 1'b1;
      @(negedge clk);
      job_valid = 1'b0;
      checks++; if ($countones(start_thread) != 1) $display("FAIL ml_start: got %b want one-hot", start_thread); else passes++;
      #2 reset_n = 1'b0;
      #1;
      checks++; if (start_thread !== 4'b0000) $display("FAIL ml_start_clr: got %b want 0000", start_thread); else passes++;
      checks++; if (dispatch_valid !== 1'b0) $display("FAIL ml_dvalid: got %b want 0", dispatch_valid); else passes++;
      checks++; if (timeout_err !== 4'b0000) $display("FAIL ml_terr: got %b want 0000", timeout_err); else passes++;
      checks++; if (done_count !== 4'd0) $display("FAIL ml_cnt: got %0d want 0", done_count); else passes++;
      checks++; if (all_idle !== 1'b1) $display("FAIL ml_idle: got %b want 1", all_idle); else passes++;
      @(negedge clk);
      reset_n = 1'b1;
      bad = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (start_thread !== 4'b0000 || debug_commands !== 4'b0000 || dispatch_valid !== 1'b0) bad++;
      end
      checks++; if (bad != 0) $display("FAIL ml_no_pulse: got %0d pulse cycles want 0", bad); else passes++;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_done_single();
      test_done_all();
      test_timeout_nodebug();
      test_debug_kick();
      test_saturation();
      test_reset_midlaunch();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
